// File: rtl/led_strip_pkg.sv
// Shared definitions for the LED-strip frame path.
// Contents:
//   START_BYTE / END_BYTE   - fill bytes of the start and end frames
//   HDR_PREFIX              - top three bits of every per-LED header byte
//   BYTES_PER_LED           - header + blue + green + red
//   START_BYTES             - length of the zero start frame
//   frame_state_e           - frame sequencer states
//   issue_state_e           - byte handshake states
//   led_header()            - builds a header byte from a 5-bit brightness
package led_strip_pkg;

   localparam logic [7:0]  START_BYTE    = 8'h00;
   localparam logic [7:0]  END_BYTE      = 8'hFF;
   localparam logic [2:0]  HDR_PREFIX    = 3'b111;
   localparam int unsigned BYTES_PER_LED = 4;
   // The start frame is exactly one LED frame wide.
   localparam int unsigned START_BYTES   = BYTES_PER_LED;

   typedef enum logic [3:0] {
      StIdle,
      StStartFrame,
      StFetch,
      StLatch,
      StLedHdr,
      StLedB,
      StLedG,
      StLedR,
      StEndFrame,
      StDone,
      StError
   } frame_state_e;

   typedef enum logic [1:0] {
      IsIdle,
      IsIssue,
      IsWaitAck,
      IsWaitDone
   } issue_state_e;

   function automatic logic [7:0] led_header(input logic [4:0] bright);
      return {HDR_PREFIX, bright};
   endfunction

endpackage

// File: rtl/led_byte_issuer.sv
// Single-byte handshake towards the SPI byte writer.
// A send_req (accepted only while idle) latches send_data, waits for the writer
// to be free, pulses byte_start for one cycle, waits for byte_busy to rise
// (bounded by ACK_TIMEOUT cycles) and then for it to fall.
// Ports:
//   spi_clk, spi_reset      - clock, asynchronous active-high reset
//   send_req, send_data     - request to send one byte (ignored unless idle)
//   send_done               - one-cycle pulse: byte fully handed over
//   send_timeout            - one-cycle pulse: byte_busy never rose
//   byte_start, byte_data   - to SPI byte writer; byte_data held for the whole handshake
//   byte_busy               - from SPI byte writer
module led_byte_issuer
   import led_strip_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic       spi_clk,
   input  logic       spi_reset,
   input  logic       send_req,
   input  logic [7:0] send_data,
   output logic       send_done,
   output logic       send_timeout,
   output logic       byte_start,
   output logic [7:0] byte_data,
   input  logic       byte_busy
);

   localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   issue_state_e    state_q, state_d;
   logic [7:0]      data_q, data_d;
   logic [TO_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge spi_clk or posedge spi_reset) begin
      if (spi_reset) begin
         state_q <= IsIdle;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      byte_start   = 1'b0;
      send_done    = 1'b0;
      send_timeout = 1'b0;
      unique case (state_q)
         IsIdle: begin
            if (send_req) begin
               data_d  = send_data;
               state_d = IsIssue;
            end
         end
         IsIssue: begin
            if (!byte_busy) begin
               byte_start = 1'b1;
               cnt_d      = '0;
               state_d    = IsWaitAck;
            end
         end
         IsWaitAck: begin
            if (byte_busy) begin
               state_d = IsWaitDone;
            end else if (cnt_q == TO_LAST) begin
               // ACK_TIMEOUT cycles seen without busy: abort and drop the byte.
               send_timeout = 1'b1;
               data_d       = '0;
               state_d      = IsIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IsWaitDone: begin
            if (!byte_busy) begin
               send_done = 1'b1;
               state_d   = IsIdle;
            end
         end
         default: state_d = IsIdle;
      endcase
   end

   assign byte_data = data_q;

endmodule

// File: rtl/led_frame_sequencer.sv
// Sequences one APA102-style LED-strip frame through the SPI byte writer:
// 4 x 0x00 start frame, per pixel {111,brightness} B G R, then END_BYTES x 0xFF.
// Ports:
//   spi_clk, spi_reset      - clock, asynchronous active-high reset
//   frame_start             - frame request, sampled only when idle
//   brightness              - 5-bit global brightness, captured on accept
//   frame_busy              - high from accepted request until DONE/ERROR exit
//   frame_done, frame_error - one-cycle completion / timeout-abort pulses
//   pixel_addr, pixel_data  - synchronous pixel RAM (1-cycle read latency)
//   byte_start, byte_data   - to SPI byte writer
//   byte_busy               - from SPI byte writer
module led_frame_sequencer
   import led_strip_pkg::*;
#(
   parameter int unsigned NUM_LEDS    = 60,
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned END_BYTES   = 4,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic              spi_clk,
   input  logic              spi_reset,
   input  logic              frame_start,
   input  logic [4:0]        brightness,
   output logic              frame_busy,
   output logic              frame_done,
   output logic              frame_error,
   output logic [ADDR_W-1:0] pixel_addr,
   input  logic [23:0]       pixel_data,
   output logic              byte_start,
   output logic [7:0]        byte_data,
   input  logic              byte_busy
);

   localparam int unsigned CNT_MAX = (END_BYTES > START_BYTES) ? END_BYTES : START_BYTES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_BYTES - 1);
   localparam logic [CNT_W-1:0]  END_LAST   = CNT_W'(END_BYTES - 1);
   localparam logic [ADDR_W-1:0] LAST_LED   = ADDR_W'(NUM_LEDS - 1);

   frame_state_e      state_q, state_d;
   logic [4:0]        bright_q, bright_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0] led_idx_q, led_idx_d;
   logic [23:0]       pix_q, pix_d;
   logic              in_flight_q, in_flight_d;
   logic              busy_q, busy_d;

   logic              is_send;
   logic              send_req;
   logic [7:0]        send_data;
   logic              send_done;
   logic              send_timeout;
   logic              byte_sent;
   logic              byte_lost;

   always_ff @(posedge spi_clk or posedge spi_reset) begin
      if (spi_reset) begin
         state_q     <= StIdle;
         bright_q    <= '0;
         byte_cnt_q  <= '0;
         led_idx_q   <= '0;
         pix_q       <= '0;
         in_flight_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bright_q    <= bright_d;
         byte_cnt_q  <= byte_cnt_d;
         led_idx_q   <= led_idx_d;
         pix_q       <= pix_d;
         in_flight_q <= in_flight_d;
         busy_q      <= busy_d;
      end
   end

   // Byte to send in each sending state.
   always_comb begin
      is_send   = 1'b1;
      send_data = START_BYTE;
      unique case (state_q)
         StStartFrame: send_data = START_BYTE;
         StLedHdr:     send_data = led_header(bright_q);
         StLedB:       send_data = pix_q[7:0];
         StLedG:       send_data = pix_q[15:8];
         StLedR:       send_data = pix_q[23:16];
         StEndFrame:   send_data = END_BYTE;
         default:      is_send   = 1'b0;
      endcase
   end

   // One request per byte: raised on the first cycle of a sending state, then
   // the state waits for the issuer to report done or timeout.
   assign send_req  = is_send && !in_flight_q;
   assign byte_sent = is_send && in_flight_q && send_done;
   assign byte_lost = is_send && in_flight_q && send_timeout;

   always_comb begin
      state_d     = state_q;
      bright_d    = bright_q;
      byte_cnt_d  = byte_cnt_q;
      led_idx_d   = led_idx_q;
      pix_d       = pix_q;
      busy_d      = busy_q;
      in_flight_d = in_flight_q;
      frame_done  = 1'b0;
      frame_error = 1'b0;

      if (send_req) begin
         in_flight_d = 1'b1;
      end else if (byte_sent || byte_lost) begin
         in_flight_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (frame_start) begin
               bright_d   = brightness;
               busy_d     = 1'b1;
               byte_cnt_d = '0;
               led_idx_d  = '0;
               state_d    = StStartFrame;
            end
         end
         StStartFrame: begin
            if (byte_sent) begin
               if (byte_cnt_q == START_LAST) begin
                  byte_cnt_d = '0;
                  state_d    = StFetch;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
         // pixel_addr is led_idx_q, already stable for the whole FETCH cycle,
         // so the RAM word is on pixel_data during LATCH.
         StFetch: state_d = StLatch;
         StLatch: begin
            pix_d   = pixel_data;
            state_d = StLedHdr;
         end
         StLedHdr: if (byte_sent) state_d = StLedB;
         StLedB:   if (byte_sent) state_d = StLedG;
         StLedG:   if (byte_sent) state_d = StLedR;
         StLedR: begin
            if (byte_sent) begin
               if (led_idx_q == LAST_LED) begin
                  led_idx_d = '0;
                  state_d   = StEndFrame;
               end else begin
                  led_idx_d = led_idx_q + 1'b1;
                  state_d   = StFetch;
               end
            end
         end
         StEndFrame: begin
            if (byte_sent) begin
               if (byte_cnt_q == END_LAST) begin
                  byte_cnt_d = '0;
                  state_d    = StDone;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            frame_done = 1'b1;
            busy_d     = 1'b0;
            state_d    = StIdle;
         end
         StError: begin
            frame_error = 1'b1;
            busy_d      = 1'b0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A lost byte aborts the frame from any sending state.
      if (byte_lost) begin
         state_d = StError;
      end
   end

   assign frame_busy = busy_q;
   assign pixel_addr = led_idx_q;

   led_byte_issuer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_issuer (
      .spi_clk      (spi_clk),
      .spi_reset    (spi_reset),
      .send_req     (send_req),
      .send_data    (send_data),
      .send_done    (send_done),
      .send_timeout (send_timeout),
      .byte_start   (byte_start),
      .byte_data    (byte_data),
      .byte_busy    (byte_busy)
   );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: behavioural SPI byte writer, synchronous pixel
// RAM, and an expected byte stream built directly from the frame format.
module tb_led_frame_sequencer;

   localparam int unsigned NLEDS       = 2;
   localparam int unsigned AW          = 6;
   localparam int unsigned ENDB        = 4;
   localparam int unsigned ACKTO       = 15;
   localparam int unsigned FRAME_BYTES = 4 + 4 * NLEDS + ENDB;

   logic          spi_clk = 1'b0;
   logic          spi_reset;
   logic          frame_start;
   logic [4:0]    brightness;
   logic          frame_busy;
   logic          frame_done;
   logic          frame_error;
   logic [AW-1:0] pixel_addr;
   logic [23:0]   pixel_data;
   logic          byte_start;
   logic [7:0]    byte_data;
   logic          byte_busy = 1'b0;

   always #5 spi_clk = ~spi_clk;

   led_frame_sequencer #(
      .NUM_LEDS    (NLEDS),
      .ADDR_W      (AW),
      .END_BYTES   (ENDB),
      .ACK_TIMEOUT (ACKTO)
   ) dut (
      .spi_clk     (spi_clk),
      .spi_reset   (spi_reset),
      .frame_start (frame_start),
      .brightness  (brightness),
      .frame_busy  (frame_busy),
      .frame_done  (frame_done),
      .frame_error (frame_error),
      .pixel_addr  (pixel_addr),
      .pixel_data  (pixel_data),
      .byte_start  (byte_start),
      .byte_data   (byte_data),
      .byte_busy   (byte_busy)
   );

   // Synchronous pixel RAM, one cycle read latency.
   logic [23:0] ram [0:(1 << AW) - 1];
   always @(posedge spi_clk) pixel_data <= ram[pixel_addr];

   // Byte writer: busy rises wr_ack_dly cycles after a start, stays wr_busy_len cycles.
   int wr_ack_dly  = 1;
   int wr_busy_len = 2;
   bit wr_never    = 1'b0;
   int dly_cnt     = 0;
   int busy_cnt    = 0;
   always @(posedge spi_clk or posedge spi_reset) begin
      if (spi_reset) begin
         byte_busy <= 1'b0;
         dly_cnt   <= 0;
         busy_cnt  <= 0;
      end else if (byte_start === 1'b1 && !wr_never) begin
         if (wr_ack_dly == 0) begin
            byte_busy <= 1'b1;
            busy_cnt  <= wr_busy_len;
         end else begin
            dly_cnt <= wr_ack_dly;
         end
      end else if (dly_cnt != 0) begin
         dly_cnt <= dly_cnt - 1;
         if (dly_cnt == 1) begin
            byte_busy <= 1'b1;
            busy_cnt  <= wr_busy_len;
         end
      end else if (byte_busy) begin
         if (busy_cnt <= 1) byte_busy <= 1'b0;
         else busy_cnt <= busy_cnt - 1;
      end
   end

   // Monitor: logs every byte handed over and tracks handshake violations.
   int         cyc = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         done_cnt = 0, err_cnt = 0, stab_err = 0, ovl_err = 0;
   int         start_cyc = 0, err_cyc = 0;
   bit         hs_open = 1'b0, hs_seen_busy = 1'b0;
   logic [7:0] hs_data = 8'h00;

   always @(posedge spi_clk) cyc <= cyc + 1;

   always @(negedge spi_clk) begin
      if (spi_reset === 1'b1) begin
         hs_open <= 1'b0;
      end else begin
         if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
         if (frame_error === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
            hs_open <= 1'b0;
         end
         if (byte_start === 1'b1) begin
            got_q.push_back(byte_data);
            start_cyc <= cyc;
            if (byte_busy === 1'b1 || hs_open) ovl_err <= ovl_err + 1;
            hs_open      <= 1'b1;
            hs_seen_busy <= 1'b0;
            hs_data      <= byte_data;
         end else if (hs_open && frame_error !== 1'b1) begin
            if (byte_data !== hs_data) stab_err <= stab_err + 1;
            if (byte_busy === 1'b1) hs_seen_busy <= 1'b1;
            else if (hs_seen_busy) hs_open <= 1'b0;
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected frame straight from the wire format.
   task automatic build_exp(input logic [4:0] br);
      exp_q.delete();
      repeat (4) exp_q.push_back(8'h00);
      for (int i = 0; i < NLEDS; i++) begin
         exp_q.push_back({3'b111, br});
         exp_q.push_back(ram[i][7:0]);
         exp_q.push_back(ram[i][15:8]);
         exp_q.push_back(ram[i][23:16]);
      end
      repeat (ENDB) exp_q.push_back(8'hFF);
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
   endtask

   task automatic start_frame(input logic [4:0] br);
      @(negedge spi_clk);
      frame_start = 1'b1;
      brightness  = br;
      @(negedge spi_clk);
      frame_start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n  = 0;
      int d0 = done_cnt;
      int e0 = err_cnt;
      while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
         @(negedge spi_clk);
         n++;
      end
      chk(tag, 32'(n < budget), 1);
   endtask

   task automatic rand_ram();
      for (int i = 0; i < NLEDS; i++) ram[i] = 24'($urandom);
   endtask

   int         d0, e0, s0, o0;
   logic [4:0] br;

   task automatic clear_log();
      got_q.delete();
      d0 = done_cnt;
      e0 = err_cnt;
      s0 = stab_err;
      o0 = ovl_err;
   endtask

   initial begin
      int n;
      int k;
      spi_reset   = 1'b1;
      frame_start = 1'b0;
      brightness  = 5'h00;
      for (int i = 0; i < (1 << AW); i++) ram[i] = 24'($urandom);
      repeat (3) @(negedge spi_clk);

      // Reset state
      chk("rst_frame_busy", 32'(frame_busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_frame_error", 32'(frame_error), 0);
      chk("rst_byte_start", 32'(byte_start), 0);
      chk("rst_byte_data", 32'(byte_data), 0);
      chk("rst_pixel_addr", 32'(pixel_addr), 0);
      spi_reset = 1'b0;
      repeat (2) @(negedge spi_clk);

      // Directed two-pixel frame
      ram[0] = 24'h112233;
      ram[1] = 24'hAABBCC;
      wr_ack_dly  = 1;
      wr_busy_len = 2;
      clear_log();
      start_frame(5'h1F);
      chk("t1_busy_mid", 32'(frame_busy), 1);
      wait_end("t1_end", 2000);
      exp_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h33, 8'h22, 8'h11,
               8'hFF, 8'hCC, 8'hBB, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      cmp_stream("t1");
      repeat (3) @(negedge spi_clk);
      chk("t1_done_pulses", 32'(done_cnt - d0), 1);
      chk("t1_error_pulses", 32'(err_cnt - e0), 0);
      chk("t1_busy_after", 32'(frame_busy), 0);
      chk("t1_overlap", 32'(ovl_err - o0), 0);

      // Brightness changed after capture must not reach the headers
      rand_ram();
      clear_log();
      start_frame(5'h03);
      repeat (10) @(negedge spi_clk);
      brightness = 5'h1A;
      wait_end("t2_end", 2000);
      build_exp(5'h03);
      cmp_stream("t2");

      // Slow writer: late busy, long busy
      wr_ack_dly  = 3;
      wr_busy_len = 40;
      rand_ram();
      br = 5'($urandom);
      clear_log();
      start_frame(br);
      wait_end("t3_end", 4000);
      build_exp(br);
      cmp_stream("t3");
      chk("t3_data_stable", 32'(stab_err - s0), 0);
      chk("t3_overlap", 32'(ovl_err - o0), 0);

      // Randomized writer timing, RAM and brightness
      for (int r = 0; r < 3; r++) begin
         wr_ack_dly  = int'($urandom_range(0, 4));
         wr_busy_len = int'($urandom_range(1, 6));
         rand_ram();
         br = 5'($urandom);
         clear_log();
         start_frame(br);
         wait_end($sformatf("t4_%0d_end", r), 2000);
         build_exp(br);
         cmp_stream($sformatf("t4_%0d", r));
         repeat (2) @(negedge spi_clk);
         chk($sformatf("t4_%0d_done", r), 32'(done_cnt - d0), 1);
         chk($sformatf("t4_%0d_stable", r), 32'(stab_err - s0), 0);
      end

      // Writer never acknowledges
      wr_never = 1'b1;
      clear_log();
      start_frame(5'($urandom));
      wait_end("t5_end", 300);
      repeat (5) @(negedge spi_clk);
      chk("t5_error_pulses", 32'(err_cnt - e0), 1);
      chk("t5_done_pulses", 32'(done_cnt - d0), 0);
      chk("t5_error_latency", 32'(err_cyc - start_cyc), ACKTO + 1);
      chk("t5_byte_starts", 32'(got_q.size()), 1);
      chk("t5_busy_after", 32'(frame_busy), 0);
      chk("t5_byte_start_after", 32'(byte_start), 0);
      chk("t5_byte_data_after", 32'(byte_data), 0);
      wr_never = 1'b0;

      // frame_start held high: back-to-back frames, pulses mid-frame ignored
      wr_ack_dly  = 0;
      wr_busy_len = 3;
      rand_ram();
      br = 5'($urandom);
      clear_log();
      @(negedge spi_clk);
      frame_start = 1'b1;
      brightness  = br;
      n = 0;
      while (frame_done !== 1'b1 && n < 3000) begin
         @(negedge spi_clk);
         n++;
      end
      chk("t6_first_done", 32'(n < 3000), 1);
      @(negedge spi_clk);
      chk("t6_idle_done_low", 32'(frame_done), 0);
      chk("t6_idle_busy_low", 32'(frame_busy), 0);
      @(negedge spi_clk);
      chk("t6_next_accepted", 32'(frame_busy), 1);
      frame_start = 1'b0;
      for (int p = 0; p < 3; p++) begin
         repeat (10) @(negedge spi_clk);
         frame_start = 1'b1;
         @(negedge spi_clk);
         frame_start = 1'b0;
      end
      n = 0;
      while (frame_done !== 1'b1 && n < 3000) begin
         @(negedge spi_clk);
         n++;
      end
      chk("t6_second_done", 32'(n < 3000), 1);
      repeat (30) @(negedge spi_clk);
      chk("t6_no_third_frame", 32'(frame_busy), 0);
      chk("t6_done_pulses", 32'(done_cnt - d0), 2);
      build_exp(br);
      for (int i = 0; i < FRAME_BYTES; i++) exp_q.push_back(exp_q[i]);
      cmp_stream("t6");

      // Reset during LED_G of pixel 1, then a clean frame
      wr_ack_dly  = 1;
      wr_busy_len = 2;
      rand_ram();
      clear_log();
      start_frame(5'($urandom));
      n = 0;
      k = 0;
      while (k < 11 && n < 2000) begin
         @(negedge spi_clk);
         if (byte_start === 1'b1) k++;
         n++;
      end
      chk("t7_reached_led_g", 32'(k), 11);
      spi_reset = 1'b1;
      #1;
      chk("t7_rst_frame_busy", 32'(frame_busy), 0);
      chk("t7_rst_frame_done", 32'(frame_done), 0);
      chk("t7_rst_frame_error", 32'(frame_error), 0);
      chk("t7_rst_byte_start", 32'(byte_start), 0);
      chk("t7_rst_byte_data", 32'(byte_data), 0);
      chk("t7_rst_pixel_addr", 32'(pixel_addr), 0);
      repeat (3) @(negedge spi_clk);
      spi_reset = 1'b0;
      repeat (2) @(negedge spi_clk);
      chk("t7_no_done_pulse", 32'(done_cnt - d0), 0);
      chk("t7_no_error_pulse", 32'(err_cnt - e0), 0);
      br = 5'($urandom);
      clear_log();
      start_frame(br);
      wait_end("t7_end", 2000);
      build_exp(br);
      cmp_stream("t7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Sequences one complete LED-strip frame (APA102-style) through the existing byte-serial SPI writer. On a frame request it emits a 4-byte zero start frame, then one 4-byte LED frame per pixel (header with global brightness, then blue, green, red), then an all-ones end frame. Pixel colours are fetched from a synchronous pixel RAM. Sits between the pattern/animation logic and the SPI byte writer, sharing spi_clk and spi_reset with it.

Parameters:
NUM_LEDS, 60, number of pixels per frame (1..2^ADDR_W)
ADDR_W, 6, pixel RAM address width
END_BYTES, 4, number of 0xFF end-frame bytes (>=1)
ACK_TIMEOUT, 15, max cycles to wait for byte_busy to rise after byte_start

Ports:
spi_clk  in  1  clock
spi_reset  in  1  asynchronous, active-high reset
frame_start  in  1  request one frame; sampled only in IDLE
brightness  in  5  global brightness, captured on accepted frame_start
frame_busy  out  1  high from accepted request until DONE/ERROR exit
frame_done  out  1  one-cycle pulse on successful completion
frame_error  out  1  one-cycle pulse on ACK timeout abort
pixel_addr  out  ADDR_W  pixel RAM read address
pixel_data  in  24  {R[23:16],G[15:8],B[7:0]}, valid 1 cycle after pixel_addr
byte_start  out  1  one-cycle start to SPI byte writer
byte_data  out  8  byte to SPI byte writer
byte_busy  in  1  busy from SPI byte writer

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, captured brightness 0. Reset mid-frame aborts immediately; no frame_done/frame_error pulse.
- Clock/reset: spi_clk; spi_reset asynchronous, active-high.
- States: IDLE, START_FRAME, FETCH, LATCH, LED_HDR, LED_B, LED_G, LED_R, END_FRAME, DONE, ERROR.
- IDLE: frame_start=1 -> capture brightness, frame_busy<=1, byte/LED counters<=0, go START_FRAME. frame_start in any other state ignored (not queued).
- Byte send sub-flow (used by START_FRAME, LED_*, END_FRAME): ISSUE: wait byte_busy=0, then drive byte_data and pulse byte_start for exactly 1 cycle; WAIT_ACK: wait byte_busy=1 (timeout counter, ACK_TIMEOUT cycles -> ERROR); WAIT_DONE: wait byte_busy=0 -> send_done. byte_data held constant from ISSUE through WAIT_DONE exit.
- START_FRAME: send 0x00 four times -> FETCH.
- FETCH: pixel_addr<=led_index; next cycle LATCH captures pixel_data into a 24-bit holding register (1-cycle RAM latency). Fetch is done before header send; pixel_data need not be stable afterwards.
- LED_HDR: send {3'b111, brightness_q}; LED_B: holding[7:0]; LED_G: holding[15:8]; LED_R: holding[23:16].
- After LED_R: led_index==NUM_LEDS-1 -> END_FRAME (led_index<=0); else led_index+1 -> FETCH.
- END_FRAME: send 0xFF END_BYTES times -> DONE.
- DONE: frame_done=1 for one cycle, frame_busy<=0, -> IDLE. A frame_start in the DONE cycle is ignored; it is accepted the following cycle if still high.
- ERROR: frame_error=1 for one cycle, frame_busy<=0, byte_start=0, byte_data=0 -> IDLE.
- Total bytes per frame = 4 + 4*NUM_LEDS + END_BYTES; exactly that many byte_start pulses.
- Counters sized to cover max(4, END_BYTES) and NUM_LEDS without wrap; led_index never exceeds NUM_LEDS-1.

Decomposition:
- Shared package led_strip_pkg: state encoding constants, START_BYTE=8'h00, END_BYTE=8'hFF, HDR_PREFIX=3'b111, BYTES_PER_LED=4.
- One sub-module led_byte_issuer: implements the ISSUE/WAIT_ACK/WAIT_DONE handshake and timeout. Interface: send_req, send_data[7:0], send_done, send_timeout, plus the byte_* ports.

Test Plan:
- NUM_LEDS=2, END_BYTES=4, RAM {0x112233, 0xAABBCC}, brightness=5'h1F, behavioural byte writer model -> 16 byte_start pulses carrying 00 00 00 00 FF 33 22 11 FF CC BB AA FF FF FF FF; one frame_done pulse; frame_busy low afterwards.
- brightness=5'h03 captured, then changed to 5'h1A mid-frame -> all headers equal 8'hE3.
- Writer model that delays byte_busy rise by 3 cycles and holds busy 40 cycles -> byte_data stable across each handshake; no second byte_start while busy=1.
- Writer model that never raises byte_busy -> frame_error pulse exactly ACK_TIMEOUT+1 cycles after the first byte_start; no frame_done; IDLE afterwards.
- frame_start held high continuously -> back-to-back frames; the next frame accepted the cycle after DONE; frame_start pulses during a frame are ignored.
- Assert spi_reset during LED_G of pixel 1 -> all outputs 0 at once; a new frame_start produces a full, correct 16-byte frame.
